// File: rtl/count_arbiter_ctrl.sv
// count_arbiter_ctrl
// Shares one loadable up-counter between two requesters (A and B).
// A round-robin pointer picks the next owner. The window is then sequenced
// on the counter: load the start value, count up to the end value (with
// wrap), then pulse Done for one cycle.
// A requester that drops its request while in LOAD or RUN aborts its own
// window immediately. No Done pulse is issued for an aborted window.

module count_arbiter_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqA,
  input  logic [WIDTH-1:0] StartA,
  input  logic [WIDTH-1:0] EndA,
  input  logic             ReqB,
  input  logic [WIDTH-1:0] StartB,
  input  logic [WIDTH-1:0] EndB,
  input  logic [WIDTH-1:0] Count,
  output logic             GrantA,
  output logic             GrantB,
  output logic             DoneA,
  output logic             DoneB,
  output logic             CntLoad,
  output logic             CntEnable,
  output logic [WIDTH-1:0] CntData,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             owner_r;   // 0: A owns the counter, 1: B owns it
  logic             owner_s;
  logic             ptr_r;     // 0: A wins a tie, 1: B wins a tie
  logic             ptr_s;
  logic [WIDTH-1:0] start_r;
  logic [WIDTH-1:0] start_s;
  logic [WIDTH-1:0] end_r;
  logic [WIDTH-1:0] end_s;
  logic             own_req_s;
  logic             pick_b_s;
  logic             at_end_s;

  // Request of whichever requester currently holds the grant
  assign own_req_s = owner_r ? ReqB : ReqA;
  // B wins only when it is alone or the pointer names it
  assign pick_b_s  = ReqB & (~ReqA | ptr_r);
  assign at_end_s  = (Count == end_r);

  // State, owner, pointer and latched window registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
      owner_r <= 1'b0;
      ptr_r   <= 1'b0;
      start_r <= {WIDTH{1'b0}};
      end_r   <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      ptr_r   <= ptr_s;
      start_r <= start_s;
      end_r   <= end_s;
    end
  end

  // Next-state logic: arbitration in IDLE, sequencing, abort and completion
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    ptr_s   = ptr_r;
    start_s = start_r;
    end_s   = end_r;
    case (state_r)
      IDLE: begin
        if (ReqA || ReqB) begin
          owner_s = pick_b_s;
          start_s = pick_b_s ? StartB : StartA;
          end_s   = pick_b_s ? EndB : EndA;
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (!own_req_s) begin
          state_s = IDLE;
          ptr_s   = ~owner_r;
        end else begin
          state_s = RUN;
        end
      end
      RUN: begin
        if (!own_req_s) begin
          state_s = IDLE;
          ptr_s   = ~owner_r;
        end else if (at_end_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
        ptr_s   = ~owner_r;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode. Grants and Done depend on state only. Load and Enable
  // are also gated by the owner's request, so an abort cycle never touches
  // the counter.
  always_comb begin
    GrantA    = 1'b0;
    GrantB    = 1'b0;
    DoneA     = 1'b0;
    DoneB     = 1'b0;
    CntLoad   = 1'b0;
    CntEnable = 1'b0;
    CntData   = {WIDTH{1'b0}};
    Busy      = (state_r != IDLE);
    if (state_r != IDLE) begin
      GrantA = ~owner_r;
      GrantB = owner_r;
    end else begin
      GrantA = 1'b0;
      GrantB = 1'b0;
    end
    case (state_r)
      LOAD: begin
        CntLoad = own_req_s;
        CntData = start_r;
      end
      RUN: begin
        CntEnable = own_req_s & ~at_end_s;
      end
      DONE: begin
        DoneA = ~owner_r;
        DoneB = owner_r;
      end
      default: begin
        CntLoad   = 1'b0;
        CntEnable = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_count_arbiter_ctrl.sv
// Self-checking bench for count_arbiter_ctrl.
// It models the shared counter and checks every cycle against a
// window-level model. That model tracks the owner, cycles since grant and
// window length, and works out the expected outputs arithmetically.
// Directed scenarios pin cycle counts and values with literal expectations.

module tb_count_arbiter_ctrl;

  localparam int W   = 6;
  localparam int MOD = 64;

  logic         Clock;
  logic         Reset;
  logic         ReqA;
  logic [W-1:0] StartA;
  logic [W-1:0] EndA;
  logic         ReqB;
  logic [W-1:0] StartB;
  logic [W-1:0] EndB;
  logic [W-1:0] Count;
  logic         GrantA;
  logic         GrantB;
  logic         DoneA;
  logic         DoneB;
  logic         CntLoad;
  logic         CntEnable;
  logic [W-1:0] CntData;
  logic         Busy;

  count_arbiter_ctrl #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqA(ReqA), .StartA(StartA), .EndA(EndA),
    .ReqB(ReqB), .StartB(StartB), .EndB(EndB),
    .Count(Count),
    .GrantA(GrantA), .GrantB(GrantB), .DoneA(DoneA), .DoneB(DoneB),
    .CntLoad(CntLoad), .CntEnable(CntEnable), .CntData(CntData), .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // The shared counter that the block controls
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)         Count <= '0;
    else if (CntLoad)   Count <= CntData;
    else if (CntEnable) Count <= W'(Count + 6'd1);
  end

  int n_pass = 0;
  int n_tot  = 0;

  // Window-level model
  bit m_busy  = 0;
  bit m_owner = 0;
  bit m_ptr   = 0;
  int m_k     = 0;
  int m_len   = 0;
  int m_start = 0;
  int m_count = 0;

  // Last sampled DUT outputs, used by directed checks and stimulus
  bit obs_ga, obs_gb, obs_da, obs_db, obs_ld, obs_en, obs_busy;
  int obs_data, obs_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant_a"}, GrantA, 0);
    check({tag, "_grant_b"}, GrantB, 0);
    check({tag, "_done_a"}, DoneA, 0);
    check({tag, "_done_b"}, DoneB, 0);
    check({tag, "_load"}, CntLoad, 0);
    check({tag, "_enable"}, CntEnable, 0);
    check({tag, "_data"}, CntData, 0);
    check({tag, "_busy"}, Busy, 0);
  endtask

  // One cycle: sample and compare at the falling edge, advance the model,
  // then return just after the next rising edge.
  task automatic tick();
    bit own_req, done_ph, abort_c, e_ld, e_en;
    @(negedge Clock);
    obs_ga = GrantA; obs_gb = GrantB; obs_da = DoneA; obs_db = DoneB;
    obs_ld = CntLoad; obs_en = CntEnable; obs_busy = Busy;
    obs_data = CntData; obs_cnt = Count;
    if (!Reset) begin
      check_idle_outputs("rst");
      m_busy = 0; m_ptr = 0; m_count = 0; m_k = 0;
    end else begin
      own_req = m_owner ? ReqB : ReqA;
      done_ph = m_busy && (m_k == m_len + 2);
      abort_c = m_busy && !done_ph && !own_req;
      e_ld    = m_busy && (m_k == 0) && !abort_c;
      e_en    = m_busy && (m_k >= 1) && (m_k <= m_len) && !abort_c;
      check("grant_a", GrantA, m_busy && !m_owner);
      check("grant_b", GrantB, m_busy && m_owner);
      check("done_a", DoneA, done_ph && !m_owner);
      check("done_b", DoneB, done_ph && m_owner);
      check("load", CntLoad, e_ld);
      check("enable", CntEnable, e_en);
      check("busy", Busy, m_busy);
      check("count", Count, m_count);
      if (e_ld) check("load_data", CntData, m_start);
      if (e_ld) m_count = m_start;
      else if (e_en) m_count = (m_count + 1) % MOD;
      if (!m_busy) begin
        if (ReqA || ReqB) begin
          m_owner = (ReqA && ReqB) ? m_ptr : ReqB;
          m_start = m_owner ? int'(StartB) : int'(StartA);
          m_len   = m_owner ? (int'(EndB) - int'(StartB) + MOD) % MOD
                            : (int'(EndA) - int'(StartA) + MOD) % MOD;
          m_k     = 0;
          m_busy  = 1;
        end
      end else if (done_ph || abort_c) begin
        m_busy = 0;
        m_ptr  = !m_owner;
      end else begin
        m_k++;
      end
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    ReqA = 1'b0; ReqB = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_count", Count, 0);
    tick();
    Reset = 1'b1;
  endtask

  // Runs until the chosen requester's Done pulse (bounded), then drops its request
  task automatic run_until_done(input bit b, output int grant_at, output int done_at,
                                output int ens, output int ld);
    grant_at = -1; done_at = -1; ens = 0; ld = -1;
    for (int i = 0; i < 150; i++) begin
      tick();
      if ((b ? obs_gb : obs_ga) && grant_at < 0) grant_at = i;
      if (obs_ld) ld = obs_data;
      if (obs_en) ens++;
      if (b ? obs_db : obs_da) begin
        done_at = i;
        break;
      end
    end
    if (done_at < 0) check("done_timeout", 0, 1);
    if (b) ReqB = 1'b0;
    else   ReqA = 1'b0;
  endtask

  initial begin
    int g, d, e, l;
    Reset = 1'b0;
    ReqA = 1'b0; ReqB = 1'b0;
    StartA = '0; EndA = '0; StartB = '0; EndB = '0;
    #1;
    check_idle_outputs("por");
    tick();
    Reset = 1'b1;

    // Single request 5 -> 9
    ReqA = 1'b1; StartA = 6'd5; EndA = 6'd9;
    run_until_done(1'b0, g, d, e, l);
    check("single_grant_at", g, 1);
    check("single_done_at", d, 7);
    check("single_enables", e, 4);
    check("single_load_data", l, 5);
    tick();
    check("single_busy_after", obs_busy, 0);
    check("single_count_end", obs_cnt, 9);

    // Wrap-around 60 -> 2 on B
    ReqB = 1'b1; StartB = 6'd60; EndB = 6'd2;
    run_until_done(1'b1, g, d, e, l);
    check("wrap_grant_at", g, 1);
    check("wrap_done_at", d, 9);
    check("wrap_enables", e, 6);
    tick();
    check("wrap_count_end", obs_cnt, 2);
    tick();
    check("wrap_count_hold", obs_cnt, 2);

    // Contention from reset: A first, B after one IDLE cycle, then A again
    do_reset();
    ReqA = 1'b1; StartA = 6'd0; EndA = 6'd3;
    ReqB = 1'b1; StartB = 6'd10; EndB = 6'd12;
    run_until_done(1'b0, g, d, e, l);
    check("rr_a_first_grant", g, 1);
    check("rr_a_enables", e, 3);
    run_until_done(1'b1, g, d, e, l);
    check("rr_b_grant_after_idle", g, 1);
    check("rr_b_enables", e, 2);
    ReqA = 1'b1; ReqB = 1'b1;
    tick();
    tick();
    check("rr_third_grant_a", obs_ga, 1);
    check("rr_third_grant_b", obs_gb, 0);
    run_until_done(1'b0, g, d, e, l);
    run_until_done(1'b1, g, d, e, l);

    // Start == End
    tick();
    ReqA = 1'b1; StartA = 6'd36; EndA = 6'd36;
    run_until_done(1'b0, g, d, e, l);
    check("eq_grant_at", g, 1);
    check("eq_done_at", d, 3);
    check("eq_enables", e, 0);
    check("eq_load_data", l, 36);

    // Abort at Count == 7 with B pending
    do_reset();
    ReqA = 1'b1; StartA = 6'd4; EndA = 6'd20;
    ReqB = 1'b1; StartB = 6'd1; EndB = 6'd2;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (obs_ga && obs_cnt == 6) break;
    end
    check("abort_reached_6", obs_cnt, 6);
    ReqA = 1'b0;
    tick();
    check("abort_cycle_count", obs_cnt, 7);
    check("abort_cycle_enable", obs_en, 0);
    check("abort_cycle_done_a", obs_da, 0);
    tick();
    check("abort_next_grant_a", obs_ga, 0);
    check("abort_next_done_a", obs_da, 0);
    tick();
    check("abort_b_granted", obs_gb, 1);
    run_until_done(1'b1, g, d, e, l);

    // Async reset mid-RUN, then a lone B request
    tick();
    ReqA = 1'b1; StartA = 6'd0; EndA = 6'd50;
    for (int i = 0; i < 6; i++) tick();
    check("mid_run_enable", obs_en, 1);
    #2;
    do_reset();
    ReqB = 1'b1; StartB = 6'd3; EndB = 6'd5;
    tick();
    check("post_rst_idle_grant_b", obs_gb, 0);
    tick();
    check("post_rst_grant_b", obs_gb, 1);
    check("post_rst_grant_a", obs_ga, 0);
    run_until_done(1'b1, g, d, e, l);

    // Randomized traffic, including aborts and input changes after grant
    for (int i = 0; i < 3000; i++) begin
      if (obs_ga && !obs_da) ReqA = ($urandom_range(0, 49) != 0);
      else if (obs_da)       ReqA = 1'b0;
      else if ($urandom_range(0, 3) == 0) ReqA = ~ReqA;
      if (obs_gb && !obs_db) ReqB = ($urandom_range(0, 49) != 0);
      else if (obs_db)       ReqB = 1'b0;
      else if ($urandom_range(0, 3) == 0) ReqB = ~ReqB;
      StartA = W'($urandom_range(0, MOD - 1));
      EndA   = W'($urandom_range(0, MOD - 1));
      StartB = W'($urandom_range(0, MOD - 1));
      EndB   = W'($urandom_range(0, MOD - 1));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
